// File: rtl/noc_pkg.sv
// noc_pkg: shared widths, source encoding and sizing helper for the ingress merge
package noc_pkg;

    localparam int NOC_DATA_WIDTH = 16;

    typedef enum logic {
        SRC_IN0 = 1'b0,
        SRC_IN1 = 1'b1
    } src_e;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ingress_fifo.sv
// ingress_fifo: small FIFO that accepts a write while full if a read frees a slot in the same cycle
module ingress_fifo
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en_i,
    input  logic [DATA_WIDTH-1:0]       wr_data_i,
    input  logic                        rd_en_i,
    output logic [DATA_WIDTH-1:0]       rd_data_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [level_w(DEPTH)-1:0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  do_wr, do_rd;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign empty_o   = wr_ptr_q == rd_ptr_q;
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the slot the write lands in, so full only blocks writes without a pop
    always_comb begin
        do_rd    = rd_en_i && !empty_o;
        do_wr    = wr_en_i && (!full_o || do_rd);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array needs no reset: pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/router_ingress_merge.sv
// router_ingress_merge: buffers two backpressure-free router streams and round-robin merges them into one valid/ready port
module router_ingress_merge
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       in0_data_i,
    input  logic                        in0_enable_i,
    input  logic [DATA_WIDTH-1:0]       in1_data_i,
    input  logic                        in1_enable_i,
    output logic [DATA_WIDTH-1:0]       out_data_o,
    output logic                        out_valid_o,
    output logic                        out_src_o,
    input  logic                        out_ready_i,
    output logic [1:0]                  overflow_o,
    output logic [CNT_WIDTH-1:0]        drop_cnt0_o,
    output logic [CNT_WIDTH-1:0]        drop_cnt1_o,
    output logic [level_w(DEPTH)-1:0]   level0_o,
    output logic [level_w(DEPTH)-1:0]   level1_o,
    input  logic                        clear_i
);

    logic [DATA_WIDTH-1:0] rd0, rd1, out_data_q, out_data_d;
    logic                  full0, full1, empty0, empty1;
    logic                  load, grant1, pop0, pop1, tie;
    logic                  out_valid_q, out_valid_d;
    src_e                  out_src_q, out_src_d, rr_last_q, rr_last_d;
    logic [1:0]            drop, ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]  cnt_q [2];
    logic [CNT_WIDTH-1:0]  cnt_d [2];

    ingress_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (in0_enable_i),
        .wr_data_i (in0_data_i),
        .rd_en_i   (pop0),
        .rd_data_o (rd0),
        .full_o    (full0),
        .empty_o   (empty0),
        .level_o   (level0_o)
    );

    ingress_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (in1_enable_i),
        .wr_data_i (in1_data_i),
        .rd_en_i   (pop1),
        .rd_data_o (rd1),
        .full_o    (full1),
        .empty_o   (empty1),
        .level_o   (level1_o)
    );

    // Arbitrate when the output register is free; rr_last only moves on a real contest
    always_comb begin
        load        = !out_valid_q || out_ready_i;
        tie         = !empty0 && !empty1;
        grant1      = !empty1 && (empty0 || rr_last_q == SRC_IN0);
        pop0        = load && !empty0 && !grant1;
        pop1        = load && grant1;
        rr_last_d   = (load && tie) ? (grant1 ? SRC_IN1 : SRC_IN0) : rr_last_q;
        out_valid_d = load ? (!empty0 || !empty1) : out_valid_q;
        out_data_d  = (pop0 || pop1) ? (grant1 ? rd1 : rd0) : out_data_q;
        out_src_d   = pop1 ? SRC_IN1 : pop0 ? SRC_IN0 : out_src_q;
    end

    // Drops happen only when full with no pop; clear still records a same-cycle drop
    always_comb begin
        drop[0] = in0_enable_i && full0 && !pop0;
        drop[1] = in1_enable_i && full1 && !pop1;
        ovf_d   = clear_i ? drop : (ovf_q | drop);
        for (int i = 0; i < 2; i++)
            cnt_d[i] = clear_i ? CNT_WIDTH'(drop[i]) :
                       (drop[i] && !(&cnt_q[i])) ? cnt_q[i] + CNT_WIDTH'(1) : cnt_q[i];
    end

    // Output register, arbiter history and drop statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_IN0;
            rr_last_q   <= SRC_IN1;
            ovf_q       <= '0;
            cnt_q       <= '{default: '0};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_last_q   <= rr_last_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign overflow_o  = ovf_q;
    assign drop_cnt0_o = cnt_q[0];
    assign drop_cnt1_o = cnt_q[1];

endmodule

// File: tb/tb_router_ingress_merge.sv
// tb_router_ingress_merge: directed stimulus with a scoreboard queue checked by an output monitor
module tb_router_ingress_merge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in0_data = '0, in1_data = '0, out_data;
    logic        in0_en = 1'b0, in1_en = 1'b0, out_ready = 1'b0, clear = 1'b0;
    logic        out_valid, out_src;
    logic [1:0]  overflow;
    logic [7:0]  cnt0, cnt1;
    logic [2:0]  level0, level1;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [16:0] sb [$];

    router_ingress_merge #(.DATA_WIDTH(16), .DEPTH(4), .CNT_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in0_data_i   (in0_data),
        .in0_enable_i (in0_en),
        .in1_data_i   (in1_data),
        .in1_enable_i (in1_en),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_src_o    (out_src),
        .out_ready_i  (out_ready),
        .overflow_o   (overflow),
        .drop_cnt0_o  (cnt0),
        .drop_cnt1_o  (cnt1),
        .level0_o     (level0),
        .level1_o     (level1),
        .clear_i      (clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic src, input logic [15:0] d);
        sb.push_back({src, d});
    endtask

    // Inputs change just after posedge, so at negedge a valid&ready pair is a committed handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e[15:0]));
                check("out_src", 32'(out_src), 32'(e[16]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_src", 32'(out_src), 0);
        check("rst_levels", {level0, level1}, 0);
        check("rst_cnts", {cnt0, cnt1}, 0);
        check("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();

        // Single word: two-cycle latency to out_valid
        in0_en = 1; in0_data = 16'h1234; out_ready = 1;
        push(0, 16'h1234);
        tick();
        in0_en = 0;
        check("single_level_after_write", 32'(level0), 1);
        check("single_valid_early", 32'(out_valid), 0);
        tick();
        check("single_valid", 32'(out_valid), 1);
        check("single_data", 32'(out_data), 32'h1234);
        check("single_level_drained", 32'(level0), 0);
        tick();
        check("single_valid_cleared", 32'(out_valid), 0);

        // Alternation: both streams, strict interleave starting with in0
        for (int k = 0; k < 4; k++) begin
            in0_en = 1; in0_data = 16'h0001 + 16'(k);
            in1_en = 1; in1_data = 16'h1001 + 16'(k);
            push(0, 16'h0001 + 16'(k));
            push(1, 16'h1001 + 16'(k));
            tick();
        end
        in0_en = 0; in1_en = 0;
        repeat (8) tick();
        check("alt_drained", sb.size(), 0);

        // Stall and overflow on in1
        out_ready = 0;
        for (int k = 0; k < 7; k++) begin
            in1_en = 1; in1_data = 16'h2000 + 16'(k);
            if (k < 5) push(1, 16'h2000 + 16'(k));
            tick();
            if (k >= 1) check("stall_data_stable", 32'(out_data), 32'h2000);
        end
        in1_en = 0;
        check("stall_valid", 32'(out_valid), 1);
        check("stall_level1", 32'(level1), 4);
        check("stall_cnt1", 32'(cnt1), 2);
        check("stall_ovf", 32'(overflow), 32'b10);
        tick();
        check("stall_hold_data", 32'(out_data), 32'h2000);
        check("stall_hold_src", 32'(out_src), 1);
        out_ready = 1;
        repeat (7) tick();
        check("stall_drained", sb.size(), 0);
        clear = 1;
        tick();
        clear = 0;
        check("clear_ovf", 32'(overflow), 0);
        check("clear_cnt1", 32'(cnt1), 0);

        // Full FIFO written while popped: no drop
        out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            in0_en = 1; in0_data = 16'h3000 + 16'(k);
            push(0, 16'h3000 + 16'(k));
            tick();
        end
        in0_en = 0;
        check("fullpop_level_before", 32'(level0), 4);
        out_ready = 1; in0_en = 1; in0_data = 16'h3005;
        push(0, 16'h3005);
        tick();
        in0_en = 0;
        check("fullpop_level", 32'(level0), 4);
        check("fullpop_cnt0", 32'(cnt0), 0);
        check("fullpop_ovf", 32'(overflow), 0);
        repeat (7) tick();
        check("fullpop_drained", sb.size(), 0);

        // Saturating drop counter and clear coinciding with a drop
        out_ready = 0;
        for (int k = 0; k < 305; k++) begin
            in0_en = 1; in0_data = 16'h4000 + 16'(k);
            if (k < 5) push(0, 16'h4000 + 16'(k));
            tick();
        end
        check("sat_cnt0", 32'(cnt0), 255);
        check("sat_ovf", 32'(overflow), 32'b01);
        clear = 1;
        tick();
        clear = 0; in0_en = 0;
        check("clear_drop_cnt0", 32'(cnt0), 1);
        check("clear_drop_ovf", 32'(overflow), 32'b01);
        check("clear_keeps_level", 32'(level0), 4);
        check("clear_keeps_data", 32'(out_data), 32'h4000);

        // Asynchronous reset while holding a word
        check("pre_reset_valid", 32'(out_valid), 1);
        rst_n = 0;
        #2;
        check("async_valid", 32'(out_valid), 0);
        check("async_levels", {level0, level1}, 0);
        check("async_cnts", {cnt0, cnt1}, 0);
        check("async_ovf", 32'(overflow), 0);
        sb.delete();
        tick();
        rst_n = 1;
        out_ready = 1;
        in0_en = 1; in0_data = 16'h5000;
        in1_en = 1; in1_data = 16'h6000;
        push(0, 16'h5000);
        push(1, 16'h6000);
        tick();
        in0_en = 0; in1_en = 0;
        repeat (6) tick();
        check("post_reset_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
